// File: rtl/tx_link_scheduler.sv
// tx_link_scheduler: round-robin arbiter plus serialiser for the 6-bit
// board-to-board packet link. The winner's datagram is latched, a header
// packet carrying the source id is sent, then the datagram goes out LSB-first
// in 6-bit packets. Each packet is held for two cycles: strobe high, then low.
//
// Handshake: req[i] is a level held by the producer until ack[i] pulses for
// one cycle. ack marks the edge on which datagram i was captured, so req and
// datagram_in may change freely afterwards without affecting the frame.
module tx_link_scheduler #(
  parameter int NUM_SRC  = 4,
  parameter int MSG_BITS = 48,
  parameter int PKT_BITS = 6
) (
  input  logic                        clk_send,
  input  logic                        rst,
  input  logic                        link_en,
  input  logic [NUM_SRC-1:0]          req,
  input  logic [NUM_SRC*MSG_BITS-1:0] datagram_in,
  output logic [NUM_SRC-1:0]          ack,
  output logic [5:0]                  packet_out,
  output logic                        packet_pulse,
  output logic                        transmit_ctrl,
  output logic                        busy,
  output logic [3:0]                  grant_id,
  output logic [2:0]                  dbg_state
);

  localparam int NPKT     = (MSG_BITS + PKT_BITS - 1) / PKT_BITS;
  localparam int BUF_BITS = NPKT * PKT_BITS;
  localparam int IDW      = $clog2(NUM_SRC);
  localparam int CW       = $clog2(NPKT + 1);

  localparam logic [IDW:0]   NSRC_W  = (IDW+1)'(NUM_SRC);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_SRC - 1);
  localparam logic [CW-1:0]  NPKT_C  = CW'(NPKT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_HOLD = 3'd2,
    S_DATA = 3'd3,
    S_END  = 3'd4
  } state_t;

  state_t              state, state_d;
  logic [IDW-1:0]      rr, rr_d;
  logic [BUF_BITS-1:0] send_buf, buf_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [NUM_SRC-1:0]  ack_d;
  logic [5:0]          pkt_d;
  logic                pulse_d, tc_d, busy_d;
  logic [3:0]          gid_d;

  logic                found;
  logic [IDW-1:0]      win;
  logic [IDW:0]        sum;
  logic [IDW-1:0]      idx;

  assign dbg_state = state;

  // Round-robin search: first requester at or above rr, wrapping to 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sum = {1'b0, rr} + (IDW+1)'(k);
      if (sum >= NSRC_W) sum = sum - NSRC_W;
      idx = sum[IDW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state and next-output logic; every output is the registered copy.
  always_comb begin
    state_d = state;
    rr_d    = rr;
    buf_d   = send_buf;
    cnt_d   = cnt;
    ack_d   = '0;
    pkt_d   = packet_out;
    pulse_d = 1'b0;
    tc_d    = 1'b0;
    busy_d  = busy;
    gid_d   = grant_id;
    case (state)
      S_IDLE: begin
        if (link_en && found) begin
          buf_d      = BUF_BITS'(datagram_in[win*MSG_BITS +: MSG_BITS]);
          ack_d[win] = 1'b1;
          gid_d      = 4'(win);
          busy_d     = 1'b1;
          rr_d       = (win == LAST_ID) ? '0 : win + 1'b1;
          cnt_d      = '0;
          state_d    = S_HDR;
        end
      end
      S_HDR: begin
        pkt_d   = {2'b10, grant_id};
        pulse_d = 1'b1;
        state_d = S_HOLD;
      end
      S_DATA: begin
        pkt_d   = send_buf[5:0];
        buf_d   = send_buf >> PKT_BITS;
        cnt_d   = cnt + 1'b1;
        pulse_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        state_d = (cnt == NPKT_C) ? S_END : S_DATA;
      end
      S_END: begin
        tc_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk_send or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      rr            <= '0;
      send_buf      <= '0;
      cnt           <= '0;
      ack           <= '0;
      packet_out    <= '0;
      packet_pulse  <= 1'b0;
      transmit_ctrl <= 1'b0;
      busy          <= 1'b0;
      grant_id      <= '0;
    end else begin
      state         <= state_d;
      rr            <= rr_d;
      send_buf      <= buf_d;
      cnt           <= cnt_d;
      ack           <= ack_d;
      packet_out    <= pkt_d;
      packet_pulse  <= pulse_d;
      transmit_ctrl <= tc_d;
      busy          <= busy_d;
      grant_id      <= gid_d;
    end
  end

endmodule

// File: tb/tb_tx_link_scheduler.sv
// tb_tx_link_scheduler: scoreboard bench for the link scheduler. A frame-level
// reference model predicts each accept, the packets of the frame and the
// end-of-frame pulse; a monitor pops and compares on every DUT event.
module tb_tx_link_scheduler;

  localparam int NUM_SRC  = 4;
  localparam int MSG_BITS = 48;
  localparam int NPKT     = (MSG_BITS + 5) / 6;
  localparam int FRAME    = 2 * NPKT + 4;   // accept edge to next possible accept

  // Clock / reset
  logic clk_send = 1'b0;
  always #5 clk_send = ~clk_send;

  logic                        rst;
  logic                        link_en;
  logic [NUM_SRC-1:0]          req;
  logic [MSG_BITS-1:0]         dg [NUM_SRC];
  logic [NUM_SRC*MSG_BITS-1:0] datagram_in;
  logic [NUM_SRC-1:0]          ack;
  logic [5:0]                  packet_out;
  logic                        packet_pulse;
  logic                        transmit_ctrl;
  logic                        busy;
  logic [3:0]                  grant_id;
  logic [2:0]                  dbg_state;

  always_comb begin
    datagram_in = '0;
    for (int i = 0; i < NUM_SRC; i++) datagram_in[i*MSG_BITS +: MSG_BITS] = dg[i];
  end

  tx_link_scheduler #(.NUM_SRC(NUM_SRC), .MSG_BITS(MSG_BITS), .PKT_BITS(6)) dut (
    .clk_send      (clk_send),
    .rst           (rst),
    .link_en       (link_en),
    .req           (req),
    .datagram_in   (datagram_in),
    .ack           (ack),
    .packet_out    (packet_out),
    .packet_pulse  (packet_pulse),
    .transmit_ctrl (transmit_ctrl),
    .busy          (busy),
    .grant_id      (grant_id),
    .dbg_state     (dbg_state)
  );

  // Scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [5:0] pkt_q[$];
  int         pkt_cyc_q[$];
  logic [3:0] ack_q[$];
  int         ack_cyc_q[$];
  int         tc_q[$];

  // Reference model: frame-level view of the scheduler
  int m_rr      = 0;
  int m_next_ok = 0;
  int m_acc     = -100;
  int m_nacc    = 0;
  int m_granted = -1;
  bit auto_clear = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_flush();
    pkt_q.delete();
    pkt_cyc_q.delete();
    ack_q.delete();
    ack_cyc_q.delete();
    tc_q.delete();
    m_rr      = 0;
    m_next_ok = 0;
    m_acc     = -100;
  endtask

  // Called at each active edge with the inputs the DUT is sampling.
  task automatic model_edge();
    int w;
    logic [MSG_BITS-1:0] d;
    m_granted = -1;
    if (rst !== 1'b1) return;
    if (cyc >= m_next_ok && link_en && req != '0) begin
      w = -1;
      for (int k = 0; k < NUM_SRC; k++) begin
        int i;
        i = (m_rr + k) % NUM_SRC;
        if (w < 0 && req[i]) w = i;
      end
      d = dg[w];
      ack_q.push_back(4'(w));
      ack_cyc_q.push_back(cyc);
      pkt_q.push_back({2'b10, 4'(w)});
      pkt_cyc_q.push_back(cyc + 1);
      for (int p = 0; p < NPKT; p++) begin
        pkt_q.push_back(6'(d >> (6 * p)));
        pkt_cyc_q.push_back(cyc + 3 + 2 * p);
      end
      tc_q.push_back(cyc + 2 * NPKT + 3);
      m_rr      = (w + 1) % NUM_SRC;
      m_next_ok = cyc + FRAME;
      m_acc     = cyc;
      m_nacc++;
      m_granted = w;
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk_send);
    cyc++;
    model_edge();
    #1;
    if (auto_clear && m_granted >= 0) req[m_granted] = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_accept(output int a);
    int start;
    start = m_nacc;
    for (int t = 0; t < 3 * FRAME && m_nacc == start; t++) step();
    check("accept_seen", 64'(m_nacc != start), 64'd1);
    a = m_acc;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_packet_out"}, 64'(packet_out), 64'd0);
    check({tag, "_packet_pulse"}, 64'(packet_pulse), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_transmit_ctrl"}, 64'(transmit_ctrl), 64'd0);
    check({tag, "_grant_id"}, 64'(grant_id), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // Monitor: compares every DUT event against the expected queues
  logic       exp_busy;
  logic [3:0] e_id;
  logic [3:0] e_onehot;
  logic [5:0] e_pkt;
  int         e_c;

  always @(negedge clk_send) begin
    if (rst === 1'b1) begin
      exp_busy = (cyc >= m_acc) && (cyc <= m_acc + 2 * NPKT + 2);
      check("busy", 64'(busy), 64'(exp_busy));
      if (ack != '0) begin
        if (ack_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL ack_unexpected: got ack=%b expected none (cycle %0d)", ack, cyc);
        end else begin
          e_id     = ack_q.pop_front();
          e_c      = ack_cyc_q.pop_front();
          e_onehot = 4'b0001 << e_id;
          check("ack_vec", 64'(ack), 64'(e_onehot));
          check("ack_cycle", 64'(cyc), 64'(e_c));
          check("grant_id", 64'(grant_id), 64'(e_id));
        end
      end
      if (packet_pulse) begin
        if (pkt_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pkt_unexpected: got packet %0h expected none (cycle %0d)", packet_out, cyc);
        end else begin
          e_pkt = pkt_q.pop_front();
          e_c   = pkt_cyc_q.pop_front();
          check("packet_value", 64'(packet_out), 64'(e_pkt));
          check("packet_cycle", 64'(cyc), 64'(e_c));
        end
      end
      if (transmit_ctrl) begin
        if (tc_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL tc_unexpected: got transmit_ctrl=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e_c = tc_q.pop_front();
          check("tc_cycle", 64'(cyc), 64'(e_c));
        end
      end
    end
  end

  // Stimulus
  initial begin
    int a;
    rst     = 1'b1;
    link_en = 1'b0;
    req     = '0;
    for (int i = 0; i < NUM_SRC; i++) dg[i] = '0;
    #2 rst = 1'b0;
    #1 check_zero("reset");
    run(2);
    rst = 1'b1;

    // Single source, known payload
    dg[0]   = 48'h0000_0000_0FFF;
    link_en = 1'b1;
    req     = 4'b0001;
    run(FRAME + 5);

    // All sources requesting continuously: five frames in rotation
    for (int i = 0; i < NUM_SRC; i++) dg[i] = 48'({$urandom(), $urandom()});
    auto_clear = 1'b0;
    req = 4'b1111;
    for (int f = 0; f < 5; f++) wait_accept(a);
    req = '0;
    auto_clear = 1'b1;
    run(FRAME);

    // Serve source 2, then 0101 must wrap to 0 before 2
    req = 4'b0100;
    wait_accept(a);
    req = 4'b0101;
    run(3 * FRAME);

    // link_en dropped during the 4th data packet
    req = 4'b0001;
    wait_accept(a);
    while (cyc < a + 9) step();
    link_en = 1'b0;
    req     = 4'b0010;
    run(2 * FRAME);
    link_en = 1'b1;
    run(FRAME + 5);

    // Reset during the hold of data packet 3
    dg[0] = 48'({$urandom(), $urandom()});
    req   = 4'b0001;
    wait_accept(a);
    while (cyc < a + 8) step();
    #1 rst = 1'b0;
    model_flush();
    #1 check_zero("midreset");
    req = 4'b1000;
    run(2);
    rst = 1'b1;
    run(FRAME + 5);

    // Payload and request change right after ack
    dg[0] = 48'({$urandom(), $urandom()});
    req   = 4'b0001;
    wait_accept(a);
    step();
    dg[0] = 48'({$urandom(), $urandom()});
    run(FRAME + 5);

    // Randomized traffic
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = 1'b1;
        else if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
        if ($urandom_range(0, 5) == 0) dg[i] = 48'({$urandom(), $urandom()});
      end
      link_en = ($urandom_range(0, 9) != 0);
      step();
    end

    // Drain
    link_en = 1'b1;
    req     = '0;
    run(FRAME + 5);
    check("ack_q_empty", 64'(ack_q.size()), 64'd0);
    check("pkt_q_empty", 64'(pkt_q.size()), 64'd0);
    check("tc_q_empty", 64'(tc_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_link_scheduler.md
Name: tx_link_scheduler

Overview:
- Shares the single 6-bit inter-board packet link between NUM_SRC message producers, e.g. game state, score, enemy table and audio cue.
- Arbitrates requests round-robin and latches the winner's datagram.
- Emits one header packet carrying the source id, then serialises the datagram LSB-first as 6-bit packets with strobe and end-of-frame signalling.
- Sits between the game-logic producers and the board-to-board pin interface.

Parameters:
- NUM_SRC, 4, number of requesters (2..16).
- MSG_BITS, 48, datagram width per requester.
- PKT_BITS, 6, packet width; fixed at 6 for the link.
- NPKT, ceil(MSG_BITS/PKT_BITS) (derived, localparam), data packets per frame.

Ports:
- clk_send  in  1  link clock.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- link_en  in  1  1 = scheduler may start new frames.
- req  in  NUM_SRC  per-source request; level, held until ack.
- datagram_in  in  NUM_SRC*MSG_BITS  source i occupies bits [i*MSG_BITS +: MSG_BITS].
- ack  out  NUM_SRC  one-cycle pulse when source's datagram is latched.
- packet_out  out  6  current packet.
- packet_pulse  out  1  strobe, high for first cycle a packet is presented.
- transmit_ctrl  out  1  one-cycle end-of-frame pulse.
- busy  out  1  high from accept until frame end.
- grant_id  out  4  id of source being sent; valid while busy.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr pointer=0, all outputs 0, send buffer and packet counter 0.
- All outputs are registered.
- States: IDLE, HDR, HOLD, DATA, END.
- IDLE:
  - If link_en=1 and req!=0, pick the first set req[i] searching from rr pointer upward, wrapping at NUM_SRC-1 to 0.
  - On that edge: latch datagram i into buffer, ack[i]<=1, grant_id<=i, busy<=1, rr<=(i+1) mod NUM_SRC, cnt<=0, go HDR.
  - Otherwise stay in IDLE.
- HDR:
  - packet_out<={2'b10,grant_id[3:0]}, packet_pulse<=1, ack<=0, go HOLD.
- DATA:
  - packet_out<=buffer[5:0], buffer<=buffer>>6, cnt<=cnt+1, packet_pulse<=1, go HOLD.
- HOLD:
  - packet_pulse<=0; packet_out holds its value.
  - If cnt==NPKT, go END; else go DATA.
- END:
  - transmit_ctrl<=1, busy<=0, go IDLE.
  - transmit_ctrl clears on the next edge.
- Each packet is therefore held 2 cycles: pulse high, then pulse low.
- Frame timing from accept edge back to IDLE: 2 + 2*NPKT + 1 + 1 cycles; 20 cycles at defaults.
- Frame contents: NPKT+1 packet_pulse strobes (header plus data).
- Padding: if MSG_BITS is not a multiple of 6, upper bits of the last data packet are 0 (buffer shifts in zeros).
- Frame atomicity:
  - link_en=0 mid-frame does not abort the frame; the scheduler completes it, then waits in IDLE.
  - req or datagram_in changing after ack does not affect the frame in flight.
- Dropped requests: a req deasserted before grant is simply not served; no error.
- Back-to-back: a new arbitration occurs in the cycle after END, i.e. the IDLE cycle with transmit_ctrl=1.
  - Minimum inter-frame gap is 1 IDLE cycle.
- Fairness: a continuously requesting source waits at most NUM_SRC-1 frames.
- Reset mid-frame: immediate return to IDLE with outputs 0; the partially sent frame is abandoned.
  - No transmit_ctrl is issued for the abandoned frame.
  - rr restarts at 0.

Test Plan:
- Reset, then req=4'b0001, datagram0=48'h0000_0000_0FFF, link_en=1:
  - ack[0] pulses once.
  - Packets in order: 6'h20, 3F, 3F, 00, 00, 00, 00, 00, 00 (9 strobes).
  - transmit_ctrl pulses once, 19 cycles after ack.
- req=4'b1111 held continuously:
  - grant order 0,1,2,3,0.
  - Header packets 20,21,22,23,20.
  - Exactly 1 IDLE cycle between transmit_ctrl and the next ack.
- After source 2 served, req=4'b0101:
  - next grant is 0 (wrap from rr=3), then 2.
- Deassert link_en during the 4th data packet:
  - frame completes with 9 strobes and transmit_ctrl.
  - No new ack while link_en=0 despite req=4'b0010.
  - Grant 1 follows within 1 cycle of link_en=1.
- Assert rst=0 during HOLD of data packet 3:
  - packet_out, packet_pulse, busy, ack, transmit_ctrl are 0 immediately.
  - After release with req=4'b1000, grant is 3 and the full frame is re-sent from the header.
- Change datagram0 and drop req[0] the cycle after ack:
  - transmitted payload equals the value latched at ack.
